// File: rtl/sort4_ctrl.sv
// Loads DEPTH words, bubble-sorts them in place through an external comparator, and streams them out in ascending order.
// Latency: the first output is passes*(DEPTH-1) cycles after the last input beat, where passes is between 1 and DEPTH.
// Backpressure: in_ready is high only in LOAD and out_valid only in UNLOAD; a stalled output holds its data and last flag.
module sort4_ctrl #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] cmp_a,
  output logic [W-1:0] cmp_b,
  input  logic         cmp_gt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic [7:0]   swap_count
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [IW-1:0] PASS_END = IW'(DEPTH - 2);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SORT   = 2'd1,
    ST_UNLOAD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    mem_q [DEPTH];
  logic [W-1:0]    mem_d [DEPTH];
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic [IW-1:0]   rd_idx_q, rd_idx_d;
  logic [IW-1:0]   i_q, i_d;
  logic            swapped_q, swapped_d;
  logic [7:0]      swap_cnt_q, swap_cnt_d;

  // Neighbour of the current compare position; i never exceeds DEPTH-2 so this stays in range.
  logic [IW-1:0]   i_nx;
  assign i_nx = i_q + IW'(1);

  // Handshake qualifiers, derived from state so they never depend on the partner's valid/ready.
  logic in_fire, out_fire, load_done, pass_end, pass_swapped, unload_done;
  assign in_fire      = (state_q == ST_LOAD) && in_valid;
  assign out_fire     = (state_q == ST_UNLOAD) && out_ready;
  assign load_done    = in_fire && (wr_idx_q == LAST_IDX);
  assign pass_end     = (state_q == ST_SORT) && (i_q == PASS_END);
  // A swap in the last compare of a pass still counts towards that pass.
  assign pass_swapped = swapped_q || cmp_gt;
  assign unload_done  = out_fire && (rd_idx_q == LAST_IDX);

  // State and datapath registers; reset aborts any batch and clears storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_LOAD;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      i_q        <= '0;
      swapped_q  <= 1'b0;
      swap_cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      i_q        <= i_d;
      swapped_q  <= swapped_d;
      swap_cnt_q <= swap_cnt_d;
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= mem_d[k];
      end
    end
  end

  // Next-state logic for the LOAD -> SORT -> UNLOAD sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD: begin
        if (load_done) begin
          state_d = ST_SORT;
        end
      end
      ST_SORT: begin
        if (pass_end && !pass_swapped) begin
          state_d = ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        if (unload_done) begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Datapath next values: word capture, compare-and-swap with pass tracking, read pointer advance.
  always_comb begin
    mem_d      = mem_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    i_d        = i_q;
    swapped_d  = swapped_q;
    swap_cnt_d = swap_cnt_q;
    unique case (state_q)
      ST_LOAD: begin
        if (in_fire) begin
          mem_d[wr_idx_q] = in_data;
          if (load_done) begin
            // Arm the sorter: fresh pass from the bottom with a clean swap history.
            wr_idx_d   = '0;
            i_d        = '0;
            swapped_d  = 1'b0;
            swap_cnt_d = '0;
          end else begin
            wr_idx_d = wr_idx_q + IW'(1);
          end
        end
      end
      ST_SORT: begin
        // Strict greater-than: equal neighbours stay put, keeping the sort stable.
        if (cmp_gt) begin
          mem_d[i_q]  = mem_q[i_nx];
          mem_d[i_nx] = mem_q[i_q];
          swapped_d   = 1'b1;
          if (swap_cnt_q != 8'hFF) begin
            swap_cnt_d = swap_cnt_q + 8'd1;
          end
        end
        if (pass_end) begin
          if (pass_swapped) begin
            swapped_d = 1'b0;
            i_d       = '0;
          end else begin
            rd_idx_d = '0;
          end
        end else begin
          i_d = i_nx;
        end
      end
      ST_UNLOAD: begin
        if (out_fire) begin
          if (unload_done) begin
            rd_idx_d = '0;
            wr_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + IW'(1);
          end
        end
      end
      default: begin
        wr_idx_d = '0;
      end
    endcase
  end

  // Moore outputs decoded from the registered state and storage only.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    // Idle operand selection is fixed so the comparator inputs stay quiet outside SORT.
    cmp_a      = mem_q[0];
    cmp_b      = mem_q[1];
    swap_count = swap_cnt_q;
    unique case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
      end
      ST_SORT: begin
        busy  = 1'b1;
        cmp_a = mem_q[i_q];
        cmp_b = mem_q[i_nx];
      end
      ST_UNLOAD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = mem_q[rd_idx_q];
        out_last  = (rd_idx_q == LAST_IDX);
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sort4_ctrl.sv
// Directed bench for sort4_ctrl with a behavioural comparator and a scoreboard of expected sorted words.
// Inputs change on the falling edge; outputs are sampled on the falling edge, away from the active edge.
// Each batch checks load handshake, sort duration, swap count, output order, last flag and stall stability.
module tb_sort4_ctrl;
  localparam int DEPTH = 4;
  localparam int W     = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [W-1:0] cmp_a;
  logic [W-1:0] cmp_b;
  logic         cmp_gt;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic [7:0]   swap_count;

  always #5 clk = ~clk;

  // Behavioural stand-in for the gt4 datapath.
  assign cmp_gt = (cmp_a > cmp_b);

  sort4_ctrl #(.DEPTH(DEPTH), .W(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .cmp_a      (cmp_a),
    .cmp_b      (cmp_b),
    .cmp_gt     (cmp_gt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .swap_count (swap_count)
  );

  int         n_total = 0;
  int         n_pass  = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Push the ascending order of four packed words (word 0 in bits [3:0]).
  task automatic push_sorted(input logic [15:0] words);
    logic [3:0] a [4];
    logic [3:0] t;
    for (int k = 0; k < 4; k++) a[k] = words[4*k +: 4];
    for (int k = 1; k < 4; k++) begin
      for (int j = k; j > 0; j--) begin
        if (a[j-1] > a[j]) begin
          t = a[j]; a[j] = a[j-1]; a[j-1] = t;
        end
      end
    end
    for (int k = 0; k < 4; k++) exp_q.push_back(a[k]);
  endtask

  // Offer four words with an in_valid pattern (1s after plen); returns at the first SORT cycle.
  task automatic load_words(input string tag, input logic [15:0] words, input logic [15:0] vpat, input int plen);
    int   n = 0;
    int   c = 0;
    logic rdy_ok = 1'b1;
    while (n < 4 && c < 64) begin
      @(negedge clk);
      in_valid = (c < plen) ? vpat[c] : 1'b1;
      in_data  = words[4*n +: 4];
      if (in_ready !== 1'b1) rdy_ok = 1'b0;
      if (in_valid && in_ready) n++;
      c++;
    end
    chk({tag, "_beats_accepted"}, n, 4);
    chk({tag, "_in_ready_load"}, rdy_ok, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic run_sort(input string tag, input int exp_cycles, input int exp_swaps);
    int   cnt = 0;
    logic rdy_bad = 1'b0;
    chk({tag, "_out_valid_after_last_beat"}, out_valid, 1'b0);
    chk({tag, "_busy_after_last_beat"}, busy, 1'b1);
    while (!out_valid && cnt < 200) begin
      if (in_ready !== 1'b0) rdy_bad = 1'b1;
      if (busy) cnt++;
      @(negedge clk);
    end
    chk({tag, "_sort_cycles"}, cnt, exp_cycles);
    chk({tag, "_swap_count"}, swap_count, exp_swaps);
    chk({tag, "_in_ready_low_sort"}, rdy_bad, 1'b0);
  endtask

  // Drain the scoreboard with an out_ready pattern (1s after plen).
  task automatic unload(input string tag, input logic [15:0] rpat, input int plen);
    int         c = 0;
    int         xfers = 0;
    logic       stalled = 1'b0;
    logic       rdy_bad = 1'b0;
    logic [3:0] pd = '0;
    logic       pl = 1'b0;
    while (exp_q.size() > 0 && c < 100) begin
      out_ready = (c < plen) ? rpat[c] : 1'b1;
      if (out_valid) begin
        if (stalled) begin
          chk({tag, "_hold_data"}, out_data, pd);
          chk({tag, "_hold_last"}, out_last, pl);
        end
        chk({tag, "_out_data"}, out_data, exp_q[0]);
        chk({tag, "_out_last"}, out_last, (exp_q.size() == 1));
        if (in_ready !== 1'b0) rdy_bad = 1'b1;
        pd = out_data;
        pl = out_last;
        if (out_ready) begin
          void'(exp_q.pop_front());
          xfers++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
        end
      end
      c++;
      @(negedge clk);
    end
    chk({tag, "_transfers"}, xfers, 4);
    chk({tag, "_in_ready_low_unload"}, rdy_bad, 1'b0);
    chk({tag, "_in_ready_after"}, in_ready, 1'b1);
    chk({tag, "_out_valid_after"}, out_valid, 1'b0);
    chk({tag, "_busy_after"}, busy, 1'b0);
    out_ready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_last"}, out_last, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_out_data"}, out_data, 4'd0);
    chk({tag, "_cmp_a"}, cmp_a, 4'd0);
    chk({tag, "_cmp_b"}, cmp_b, 4'd0);
    chk({tag, "_swap_count"}, swap_count, 8'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: mixed values, two passes
    push_sorted(16'hBE19);
    load_words("t1", 16'hBE19, 16'h0, 0);
    run_sort("t1", 6, 2);
    unload("t1", 16'h0, 0);

    // 2: already sorted with an equal pair, single pass
    push_sorted(16'hF550);
    load_words("t2", 16'hF550, 16'h0, 0);
    run_sort("t2", 3, 0);
    unload("t2", 16'h0, 0);

    // 3: reverse order, worst case
    push_sorted(16'h69EF);
    load_words("t3", 16'h69EF, 16'h0, 0);
    run_sort("t3", 12, 6);
    unload("t3", 16'h0, 0);

    // 4: scenario 1 again with output stalls 1,0,0,1,0,1,1
    push_sorted(16'hBE19);
    load_words("t4", 16'hBE19, 16'h0, 0);
    run_sort("t4", 6, 2);
    unload("t4", 16'h0069, 7);

    // 5: reset in the third SORT cycle, then a batch of equal words
    push_sorted(16'h19AB);
    load_words("t5", 16'h19AB, 16'h0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_busy_before_reset", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t5_reset");
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    push_sorted(16'h7777);
    load_words("t5b", 16'h7777, 16'h0, 0);
    run_sort("t5b", 3, 0);
    unload("t5b", 16'h0, 0);

    // 6: gapped input valid 1,0,1,0,0,1,1
    push_sorted(16'h80C3);
    load_words("t6", 16'h80C3, 16'h0065, 7);
    run_sort("t6", 9, 3);
    unload("t6", 16'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
